// File: rtl/dram_arbiter.sv
// -----------------------------------------------------------------------------
// dram_arbiter
//
// Two-port round-robin arbiter and sequencer in front of the single-port dram
// data memory. Exactly one dram access is in flight at a time. Port 0 is the
// load/store unit and port 1 is DMA/debug.
//
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   pN_req/rnw/addr/wdata        request command from requester N (N = 0, 1)
//   pN_gnt                       one-cycle pulse: command accepted
//   pN_rvalid/rdata              one-cycle read-valid pulse, data held after it
//   pN_err                       one-cycle pulse: access was out of range
//   mem_address/write_data/
//   mem_read_not_write/mem_cs    registered command to the dram
//   mem_read_data                dram registered read data (valid only the
//                                cycle after a cs=1 read edge)
//   dbg_state, dbg_ptr           current FSM state and round-robin pointer
//
// Handshake: a requester raises pN_req with its command fields and holds all
// of them stable until it sees pN_gnt high; it may drop or change the request
// at the edge that ends the gnt cycle. A request that is not granted is never
// lost; it is simply served on a later IDLE edge.
// -----------------------------------------------------------------------------
module dram_arbiter #(
    parameter int ADDRESS_BUS_WIDTH = 8,
    parameter int DATA_BUS_WIDTH    = 24,
    parameter int NUM_ADDRESS       = 256
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          p0_req,
    input  logic                          p0_rnw,
    input  logic [ADDRESS_BUS_WIDTH-1:0]  p0_addr,
    input  logic [DATA_BUS_WIDTH-1:0]     p0_wdata,
    input  logic                          p1_req,
    input  logic                          p1_rnw,
    input  logic [ADDRESS_BUS_WIDTH-1:0]  p1_addr,
    input  logic [DATA_BUS_WIDTH-1:0]     p1_wdata,
    output logic                          p0_gnt,
    output logic                          p0_rvalid,
    output logic [DATA_BUS_WIDTH-1:0]     p0_rdata,
    output logic                          p0_err,
    output logic                          p1_gnt,
    output logic                          p1_rvalid,
    output logic [DATA_BUS_WIDTH-1:0]     p1_rdata,
    output logic                          p1_err,
    output logic [ADDRESS_BUS_WIDTH-1:0]  mem_address,
    output logic [DATA_BUS_WIDTH-1:0]     mem_write_data,
    output logic                          mem_read_not_write,
    output logic                          mem_cs,
    input  logic [DATA_BUS_WIDTH-1:0]     mem_read_data,
    output logic [1:0]                    dbg_state,
    output logic                          dbg_ptr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t state;
    logic   ptr;       // port that wins when both request
    logic   win;       // port owning the access in flight
    logic   win_rnw;
    logic   win_ok;    // access in flight is inside the implemented range

    // Zero-extend to 33 bits so the compare is exact for any address width.
    function automatic logic in_range(input logic [ADDRESS_BUS_WIDTH-1:0] a);
        return 33'(a) < 33'(NUM_ADDRESS);
    endfunction

    logic                         any_req;
    logic                         sel;
    logic                         sel_rnw;
    logic [ADDRESS_BUS_WIDTH-1:0] sel_addr;
    logic [DATA_BUS_WIDTH-1:0]    sel_wdata;

    always_comb begin
        any_req   = p0_req | p1_req;
        // Lone requester wins; on contention the pointer port wins.
        sel       = (p0_req && p1_req) ? ptr : p1_req;
        sel_rnw   = sel ? p1_rnw   : p0_rnw;
        sel_addr  = sel ? p1_addr  : p0_addr;
        sel_wdata = sel ? p1_wdata : p0_wdata;
    end

    assign dbg_state = state;
    assign dbg_ptr   = ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            ptr                <= 1'b0;
            win                <= 1'b0;
            win_rnw            <= 1'b1;
            win_ok             <= 1'b1;
            p0_gnt             <= 1'b0;
            p1_gnt             <= 1'b0;
            p0_rvalid          <= 1'b0;
            p1_rvalid          <= 1'b0;
            p0_err             <= 1'b0;
            p1_err             <= 1'b0;
            p0_rdata           <= '0;
            p1_rdata           <= '0;
            mem_address        <= '0;
            mem_write_data     <= '0;
            mem_read_not_write <= 1'b1;
            mem_cs             <= 1'b0;
        end else begin
            // Pulse outputs default low; the cases below raise them for one cycle.
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_err    <= 1'b0;
            p1_err    <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_req) begin
                        mem_address        <= sel_addr;
                        mem_write_data     <= sel_wdata;
                        mem_read_not_write <= sel_rnw;
                        mem_cs             <= in_range(sel_addr);
                        win                <= sel;
                        win_rnw            <= sel_rnw;
                        win_ok             <= in_range(sel_addr);
                        p0_gnt             <= ~sel;
                        p1_gnt             <= sel;
                        ptr                <= ~sel;
                        state              <= ISSUE;
                    end
                end

                ISSUE: begin
                    // The dram samples cs at this edge: a write commits here,
                    // a read produces data for the RDWAIT cycle.
                    mem_cs <= 1'b0;
                    if (win_rnw) begin
                        state <= RDWAIT;
                    end else begin
                        p0_err <= ~win & ~win_ok;
                        p1_err <= win & ~win_ok;
                        state  <= IDLE;
                    end
                end

                RDWAIT: begin
                    // mem_read_data is only driven in this cycle, and only
                    // when cs was actually raised for an in-range address.
                    if (win) begin
                        p1_rvalid <= 1'b1;
                        p1_err    <= ~win_ok;
                        p1_rdata  <= win_ok ? mem_read_data : '0;
                    end else begin
                        p0_rvalid <= 1'b1;
                        p0_err    <= ~win_ok;
                        p0_rdata  <= win_ok ? mem_read_data : '0;
                    end
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
